// File: rtl/uart_mmio_seq.sv
// rtl/uart_mmio_seq.sv - MMIO sequencer that configures a UART slave and moves TX/RX bytes
// Optional feature macro: UART_SEQ_TIMEOUT_EN (sticky TX poll timeout counter).
module uart_mmio_seq #(
  parameter int ADDR_W    = 12,
  parameter int BAUD_DIV  = 16,
  parameter int TXQ_DEPTH = 4,
  parameter int POLL_MAX  = 2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              tx_valid,
  input  logic [7:0]        tx_data,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic              m_valid,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic              m_ready,
  input  logic [31:0]       m_rdata,
  output logic              running,
  output logic              err_timeout
);
  localparam int PTR_W = $clog2(TXQ_DEPTH);

  localparam logic [ADDR_W-1:0] OFF_DATA   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] OFF_CTRL   = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] OFF_BAUD   = ADDR_W'(12);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CFG_BAUD = 3'd1;
  localparam logic [2:0] S_CFG_CTRL = 3'd2;
  localparam logic [2:0] S_POLL     = 3'd3;
  localparam logic [2:0] S_RD_DATA  = 3'd4;
  localparam logic [2:0] S_WR_DATA  = 3'd5;

  logic [2:0]        state;
  logic [2:0]        issue_state;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic [7:0]        q_mem [TXQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    q_count;
  logic              q_empty;
  logic              push;
  logic              pop;
  logic              hs;

  // Only the low byte and the two STATUS flag bits of read data matter.
  logic unused_rdata;
  assign unused_rdata = ^m_rdata[31:8];

  assign hs       = m_valid && m_ready;
  assign tx_ready = (q_count < (PTR_W+1)'(TXQ_DEPTH));
  assign q_empty  = (q_count == '0);
  assign push     = tx_valid && tx_ready;
  assign pop      = hs && (state == S_WR_DATA);

  // Queue storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= tx_data;
  end

  // TX queue pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + (PTR_W+1)'(1);
        2'b01:   q_count <= q_count - (PTR_W+1)'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  // Request fields for the next transaction; leaving IDLE always starts with the baud write.
  always_comb begin
    issue_state = (state == S_IDLE) ? S_CFG_BAUD : state;
    req_we      = 1'b0;
    req_addr    = OFF_STATUS;
    req_wdata   = 32'h0;
    case (issue_state)
      S_CFG_BAUD: begin req_we = 1'b1; req_addr = OFF_BAUD; req_wdata = 32'(BAUD_DIV); end
      S_CFG_CTRL: begin req_we = 1'b1; req_addr = OFF_CTRL; req_wdata = 32'h3; end
      S_RD_DATA:  req_addr = OFF_DATA;
      S_WR_DATA:  begin req_we = 1'b1; req_addr = OFF_DATA; req_wdata = {24'h0, q_mem[rd_ptr]}; end
      default:    ;
    endcase
  end

  // Sequencer: a request is held until its handshake, then m_valid drops for a cycle before the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      m_valid  <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= 32'h0;
      m_wstrb  <= 4'h0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h0;
      running  <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (hs) begin
        m_valid <= 1'b0;
        case (state)
          S_CFG_BAUD: state <= S_CFG_CTRL;
          S_CFG_CTRL: begin state <= S_POLL; running <= 1'b1; end
          S_POLL: begin
            if (m_rdata[0] && !rx_valid)     state <= S_RD_DATA;
            else if (m_rdata[1] && !q_empty) state <= S_WR_DATA;
            else                             state <= S_POLL;
          end
          S_RD_DATA: begin
            rx_valid <= 1'b1;
            rx_data  <= m_rdata[7:0];
            state    <= S_POLL;
          end
          S_WR_DATA: state <= S_POLL;
          default:   state <= S_IDLE;
        endcase
      end else if (!m_valid && (state != S_IDLE || start)) begin
        state   <= issue_state;
        m_valid <= 1'b1;
        m_we    <= req_we;
        m_addr  <= req_addr;
        m_wdata <= req_wdata;
        m_wstrb <= req_we ? 4'hF : 4'h0;
      end
    end
  end

`ifdef UART_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(POLL_MAX + 1);
  logic [CNT_W-1:0] poll_cnt;

  // Count polls that find TX blocked with bytes waiting; any byte written clears the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_cnt    <= '0;
      err_timeout <= 1'b0;
    end else if (hs && state == S_WR_DATA) begin
      poll_cnt <= '0;
    end else if (hs && state == S_POLL && !q_empty && !m_rdata[1]) begin
      if (poll_cnt < CNT_W'(POLL_MAX)) poll_cnt <= poll_cnt + CNT_W'(1);
      if (poll_cnt >= CNT_W'(POLL_MAX - 1)) err_timeout <= 1'b1;
    end
  end
`else
  localparam int unused_poll_max = POLL_MAX;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_mmio_seq.sv
// tb/tb_uart_mmio_seq.sv - self-checking bench for uart_mmio_seq
module tb_uart_mmio_seq;
  localparam int TB_DEPTH = 4;
`ifdef UART_SEQ_TIMEOUT_EN
  localparam int TB_POLL_MAX = 8;
`else
  localparam int TB_POLL_MAX = 2000;
`endif
  localparam int P_IDLE = 0, P_BAUD = 1, P_CTRL = 2, P_POLL = 3, P_RD = 4, P_WR = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h0;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready = 1'b0;
  logic        m_valid;
  logic        m_we;
  logic [11:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready = 1'b0;
  logic [31:0] m_rdata;
  logic        running;
  logic        err_timeout;

  logic [31:0] status_val = 32'h0;
  logic [7:0]  s_byte = 8'h00;

  int checks = 0;
  int errors = 0;

  // model state
  int          ph = P_IDLE;
  logic [7:0]  mq[$];
  bit          m_rxv = 0, m_run = 0, m_err = 0, first = 0, after_hs = 0;
  logic [7:0]  m_rxd = 8'h0, m_loop = 8'h0;
  int          m_pcnt = 0, idle_cnt = 0;
  // observation logs
  logic [63:0] obs_w[$];
  logic [3:0]  last_wstrb = 4'h0;
  int          n_poll = 0, n_rd = 0, n_baud = 0;

  uart_mmio_seq #(.ADDR_W(12), .BAUD_DIV(16), .TXQ_DEPTH(TB_DEPTH), .POLL_MAX(TB_POLL_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata), .running(running), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // slave: STATUS returns status_val, DATA loops back the last byte written
  assign m_rdata = (m_addr == 12'h004) ? status_val : {24'h0, s_byte};
  always @(posedge clk) begin
    if (m_valid && m_ready && m_we && m_addr == 12'h000) s_byte <= m_wdata[7:0];
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push(input logic [7:0] b);
    bit done = 0;
    tx_data = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      done = tx_ready;
      step(1);
    end
    tx_valid = 1'b0;
    chk("push_accept", done, 1);
  endtask

  function automatic logic [63:0] get_w(input int i);
    if (i < obs_w.size()) return obs_w[i];
    return '1;
  endfunction

  // transaction-level model, compared every cycle at the falling edge
  always @(negedge clk) begin
    bit hs, pushed, rxv_pre;
    logic e_we;
    logic [31:0] e_addr, e_wdata, st;
    if (rst) begin
      ph = P_IDLE; mq.delete(); m_rxv = 0; m_run = 0; m_err = 0;
      first = 0; after_hs = 0; m_pcnt = 0; idle_cnt = 0;
    end else begin
      chk("tx_ready", tx_ready, mq.size() < TB_DEPTH);
      chk("rx_valid", rx_valid, m_rxv);
      if (m_rxv) chk("rx_data", rx_data, m_rxd);
      chk("running", running, m_run);
      chk("err_timeout", err_timeout, m_err);
      if (ph == P_IDLE) chk("idle_no_req", m_valid, 0);
      if (first) chk("first_req_latency", m_valid, 1);
      if (after_hs) chk("req_gap", m_valid, 0);
      if (m_valid && ph != P_IDLE) begin
        e_we = 0; e_addr = 32'h4; e_wdata = 32'h0;
        case (ph)
          P_BAUD: begin e_we = 1; e_addr = 32'hC; e_wdata = 32'd16; end
          P_CTRL: begin e_we = 1; e_addr = 32'h8; e_wdata = 32'h3; end
          P_RD:   e_addr = 32'h0;
          P_WR:   begin e_we = 1; e_addr = 32'h0; e_wdata = {24'h0, mq[0]}; end
          default: ;
        endcase
        chk("m_we", m_we, e_we);
        chk("m_addr", m_addr, e_addr);
        chk("m_wdata", m_wdata, e_wdata);
        chk("m_wstrb", m_wstrb, e_we ? 4'hF : 4'h0);
      end
      if (ph != P_IDLE && !m_valid) begin
        idle_cnt++;
        chk("req_gap_len", idle_cnt <= 4, 1);
      end else idle_cnt = 0;

      hs = m_valid && m_ready;
      pushed = tx_valid && (mq.size() < TB_DEPTH);
      rxv_pre = m_rxv;
      st = status_val;
      first = 0;
      after_hs = hs;
      if (m_rxv && rx_ready) m_rxv = 0;
      if (hs) begin
        if (m_we) begin obs_w.push_back({32'(m_addr), m_wdata}); last_wstrb = m_wstrb; end
        if (m_addr == 12'h004) n_poll++;
        if (m_addr == 12'h000 && !m_we) n_rd++;
        if (m_addr == 12'h00C) n_baud++;
      end
      if (ph == P_IDLE && start) begin
        ph = P_BAUD; first = 1;
      end else if (hs) begin
        case (ph)
          P_BAUD: ph = P_CTRL;
          P_CTRL: begin ph = P_POLL; m_run = 1; end
          P_POLL: begin
`ifdef UART_SEQ_TIMEOUT_EN
            if (mq.size() > 0 && !st[1]) begin
              if (m_pcnt < TB_POLL_MAX) m_pcnt++;
              if (m_pcnt >= TB_POLL_MAX) m_err = 1;
            end
`endif
            if (st[0] && !rxv_pre) ph = P_RD;
            else if (st[1] && mq.size() > 0) ph = P_WR;
            else ph = P_POLL;
          end
          P_RD: begin m_rxv = 1; m_rxd = m_loop; ph = P_POLL; end
          P_WR: begin m_loop = mq.pop_front(); m_pcnt = 0; ph = P_POLL; end
          default: ;
        endcase
      end
      if (pushed) mq.push_back(tx_data);
    end
  end

  initial begin
    int p0;
    step(3);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_running", running, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wstrb", m_wstrb, 0);
    chk("rst_m_wdata", m_wdata, 0);
    rst = 1'b0;
    step(2);

    // configuration with a stalled first handshake
    m_ready = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    step(5);
    chk("baud_held_valid", m_valid, 1);
    chk("baud_held_addr", m_addr, 12'h00C);
    m_ready = 1'b1;
    for (int i = 0; i < 20 && !running; i++) step(1);
    chk("cfg_running", running, 1);
    chk("cfg_baud_write", get_w(0), {32'h00C, 32'd16});
    chk("cfg_ctrl_write", get_w(1), {32'h008, 32'h3});
    chk("cfg_baud_once", n_baud, 1);
    step(6);
    chk("polls_started", n_poll > 0, 1);

    // single TX byte then loopback RX
    status_val = 32'h2;
    push(8'hA5);
    for (int i = 0; i < 30 && obs_w.size() < 3; i++) step(1);
    chk("tx_a5_write", get_w(2), {32'h000, 32'hA5});
    chk("tx_a5_wstrb", last_wstrb, 4'hF);
    status_val = 32'h1;
    for (int i = 0; i < 30 && !rx_valid; i++) step(1);
    chk("rx_loop_valid", rx_valid, 1);
    chk("rx_loop_data", rx_data, 8'hA5);
    step(6);
    chk("rx_single_read", n_rd, 1);
    status_val = 32'h0;
    step(2);
    rx_ready = 1'b1; step(1); rx_ready = 1'b0;
    chk("rx_consumed", rx_valid, 0);

    // fill the queue, then drain with back-to-back pushes
    for (int b = 1; b <= 4; b++) push(8'(b));
    chk("queue_full", tx_ready, 0);
    start = 1'b1; step(1); start = 1'b0;
    status_val = 32'h2;
    for (int b = 5; b <= 9; b++) push(8'(b));
    for (int i = 0; i < 200 && obs_w.size() < 12; i++) step(1);
    for (int i = 0; i < 9; i++) chk("tx_order", get_w(3 + i), {32'h0, 32'(i + 1)});

    // RX priority with a stalled consumer
    status_val = 32'h0;
    push(8'h77);
    status_val = 32'h3;
    step(30);
    chk("rx_prio_reads", n_rd, 2);
    chk("rx_prio_data", rx_data, 8'h09);
    chk("tx_after_rx", get_w(12), {32'h0, 32'h77});
    rx_ready = 1'b1; step(1); rx_ready = 1'b0;
    step(10);
    chk("rx_after_release", n_rd, 3);
    chk("rx_after_release_data", rx_data, 8'h77);
    status_val = 32'h0;
    rx_ready = 1'b1; step(2); rx_ready = 1'b0;

    // blocked TX, then mid-run reset
    push(8'h5A);
    p0 = n_poll;
`ifdef UART_SEQ_TIMEOUT_EN
    for (int i = 0; i < 60 && !err_timeout; i++) step(1);
    chk("timeout_set", err_timeout, 1);
    chk("timeout_poll_count", n_poll - p0, TB_POLL_MAX);
    step(6);
    chk("timeout_sticky", err_timeout, 1);
`else
    step(20);
    chk("blocked_polls", n_poll - p0 >= 8, 1);
`endif
    chk("blocked_not_ready_q", obs_w.size(), 13);
    rst = 1'b1; step(2);
    chk("rst2_err", err_timeout, 0);
    chk("rst2_tx_ready", tx_ready, 1);
    chk("rst2_m_valid", m_valid, 0);
    chk("rst2_running", running, 0);
    rst = 1'b0;
    status_val = 32'h2;
    step(10);
    chk("no_resume", m_valid, 0);
    start = 1'b1; step(1); start = 1'b0;
    for (int i = 0; i < 20 && !running; i++) step(1);
    chk("restart_running", running, 1);
    step(10);
    chk("queue_cleared", obs_w.size(), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
